// File: rtl/ps2_rx_deserializer_if.sv
// Receive-side bundle of the PS/2 deserializer: byte, strobes and busy flag.
// The deserializer drives it through the master modport; consumers use slave.
interface ps2_rx_deserializer_if;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (
    output received_data,
    output received_data_en,
    output parity_err,
    output frame_err,
    output busy
  );

  modport slave (
    input received_data,
    input received_data_en,
    input parity_err,
    input frame_err,
    input busy
  );
endinterface

// File: rtl/ps2_rx_deserializer.sv
// PS/2 device-to-host frame receiver: synchronizer, clock glitch filter, frame FSM.
// Define PS2_RX_PARITY_CHECK_EN to drop odd-parity failures and pulse parity_err.
module ps2_rx_deserializer #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  CLOCK,
  input  logic                  resetn,
  input  logic                  ps2_clk,
  input  logic                  ps2_dat,
  ps2_rx_deserializer_if.master bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          fall_q, fall_d;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    data_q, data_d;
  logic          data_en_q, data_en_d;
  logic          parity_err_q, parity_err_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;
  logic          timeout;
`ifdef PS2_RX_PARITY_CHECK_EN
  logic          par_q, par_d;
`endif

  // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
      end else begin
        flt_cnt_d = flt_cnt_q + FW'(1);
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  assign timeout = (state_q != IDLE) && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_d       = data_q;
    data_en_d    = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
    par_d        = par_q;
`endif
    if (state_q == IDLE || fall_q) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end

    // A timeout takes priority over a fall arriving on the same cycle.
    if (timeout) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      bit_cnt_d   = '0;
      shift_d     = '0;
    end else if (fall_q) begin
      case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
`ifdef PS2_RX_PARITY_CHECK_EN
          par_d = dat_s2_q;
`endif
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (dat_s2_q) begin
`ifdef PS2_RX_PARITY_CHECK_EN
            if (^{shift_q, par_q}) begin
              data_d    = shift_q;
              data_en_d = 1'b1;
            end else begin
              parity_err_d = 1'b1;
            end
`else
            data_d    = shift_q;
            data_en_d = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // Sync flops and filtered clock reset to the idle-high bus level.
  always_ff @(posedge CLOCK or negedge resetn) begin
    if (!resetn) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      filt_q       <= 1'b1;
      flt_cnt_q    <= '0;
      fall_q       <= 1'b0;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      to_cnt_q     <= '0;
      data_q       <= '0;
      data_en_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
      par_q        <= 1'b0;
`endif
    end else begin
      clk_s1_q     <= ps2_clk;
      clk_s2_q     <= clk_s1_q;
      dat_s1_q     <= ps2_dat;
      dat_s2_q     <= dat_s1_q;
      filt_q       <= filt_d;
      flt_cnt_q    <= flt_cnt_d;
      fall_q       <= fall_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      to_cnt_q     <= to_cnt_d;
      data_q       <= data_d;
      data_en_q    <= data_en_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
`ifdef PS2_RX_PARITY_CHECK_EN
      par_q        <= par_d;
`endif
    end
  end

  assign bus.received_data    = data_q;
  assign bus.received_data_en = data_en_q;
  assign bus.parity_err       = parity_err_q;
  assign bus.frame_err        = frame_err_q;
  assign bus.busy             = busy_q;

endmodule

// File: doc/ps2_rx_deserializer.md
PS2_RX_DESERIALIZER -- requirements
Module: ps2_rx_deserializer

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal samples needed to accept a ps2_clk level change.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: CLOCK cycles allowed between filtered falling edges inside a frame.
REQ-003 SHALL have port CLOCK  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock line, asynchronous to CLOCK.
REQ-006 SHALL have port ps2_dat  input  1  raw PS/2 data line, asynchronous to CLOCK.
REQ-007 SHALL have port received_data  output  8  last accepted byte; held until the next accepted byte.
REQ-008 SHALL have port received_data_en  output  1  one-cycle strobe; received_data is valid on the same cycle.
REQ-009 SHALL have port parity_err  output  1  one-cycle strobe on odd-parity failure.
REQ-010 SHALL have port frame_err  output  1  one-cycle strobe on bad stop bit or timeout.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL synchronize ps2_clk and ps2_dat through 2 flops each before any other use.
REQ-013 SHALL update the filtered clock only after FILTER_LEN consecutive equal synced samples; shorter pulses are ignored.
REQ-014 SHALL generate fall, a one-cycle pulse, on a filtered-clock 1->0 transition; ps2_dat is sampled (synced) on that cycle.
REQ-015 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: on fall with data 0 -> DATA, bit count 0, timeout counter 0; with data 1 -> stay IDLE, no strobe.
REQ-017 DATA: on each fall, shift data in LSB first; after the 8th bit -> PARITY.
REQ-018 PARITY: on fall, capture the parity bit -> STOP.
REQ-019 STOP: on fall -> IDLE; stop=1 and parity good -> load received_data, pulse received_data_en; stop=0 -> pulse frame_err only.
REQ-020 Parity good SHALL mean XOR of the 8 data bits and the parity bit equals 1.
REQ-021 Strobe latency SHALL be exactly 1 cycle after the fall cycle of the stop bit; at most one strobe per frame.
REQ-022 Outside IDLE, the counter SHALL reset on each fall and otherwise increment; on reaching TIMEOUT_CYCLES -> IDLE, pulse frame_err, discard partial byte.
REQ-023 If timeout and fall coincide, timeout SHALL win.
REQ-024 Back-to-back frames SHALL be accepted; a start bit may arrive on the first fall after STOP.

Reset
REQ-025 resetn low SHALL asynchronously force state IDLE, counters 0, received_data 0x00, all strobes 0, busy 0.
REQ-026 Sync flops and filtered clock SHALL reset to 1, the idle bus level, so deassertion creates no false fall.
REQ-027 Reset mid-frame SHALL drop the partial frame with no strobe.

Configuration
REQ-028 With PS2_RX_PARITY_CHECK_EN defined, a bad-parity frame with stop=1 SHALL be dropped and parity_err pulsed instead of received_data_en.
REQ-029 Without PS2_RX_PARITY_CHECK_EN, parity SHALL be ignored, the byte delivered when stop=1, and parity_err tied 0.

Verification
REQ-030 Frame 0x1C, parity 0, stop 1 -> received_data=0x1C, received_data_en high exactly 1 cycle, no error strobes.
REQ-031 Macro defined, 0x1C with parity 1 -> no received_data_en, parity_err 1 cycle, received_data unchanged.
REQ-032 0x75 with parity 0 and stop 0 -> frame_err 1 cycle, no received_data_en, back to IDLE.
REQ-033 Five bits, then clock held high -> after TIMEOUT_CYCLES frame_err pulses, busy 0; next frame 0xF0 with parity 1 -> received_data=0xF0.
REQ-034 3-cycle low glitch on ps2_clk in IDLE (FILTER_LEN=8) -> state stays IDLE, no strobes.
REQ-035 resetn low after bit 4 of a frame -> busy 0 at once; following full frame 0x29 (parity 0) received correctly.
